// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and packer FSM state type for the FIFO drain path.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK = 4;
    typedef enum logic [1:0] {FILL, PEND, MOVE} packer_state_t;
endpackage

// File: rtl/pack_idle_timer.sv
// pack_idle_timer: counts consecutive idle cycles; expire marks the TIMEOUT-th one.
module pack_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] count;
    assign expire = idle && (count == TW'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (!idle) count <= '0;
        else if (!expire) count <= count + TW'(1);
    end
endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops FIFO bytes, packs PACK entries per word onto a valid/ready port.
// Define PACKER_FLUSH_EN to flush partial words after TIMEOUT idle cycles.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK = DEF_PACK,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic                       fifo_underflow,
    input  logic [DATA_WIDTH-1:0]      fifo_data_out,
    output logic                       fifo_rd_en,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       err_underflow
);
    localparam int CW = $clog2(PACK + 1);
    localparam int W = DATA_WIDTH * PACK;
    packer_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic rd_q, flush, do_move, busy;
    logic [W-1:0] acc;
    logic [PACK-1:0] keep;
    if (PACK < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fifo_word_packer: PACK must be >= 2 and TIMEOUT >= 1");
    end
    assign busy = m_valid && !m_ready;
    assign fifo_rd_en = rst_n && (state == FILL) && !fifo_empty &&
                        (({1'b0, cnt} + {{CW{1'b0}}, rd_q}) < (CW + 1)'(PACK));
`ifdef PACKER_FLUSH_EN
    logic idle;
    assign idle = (cnt != '0) && !rd_q && fifo_empty;
    pack_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .idle   (idle),
        .expire (flush)
    );
    always_comb begin
        keep = '0;
        for (int i = 0; i < PACK; i++) keep[i] = i < int'(cnt);
    end
`else
    assign flush = 1'b0;
    assign keep = '1;
`endif
    always_comb begin
        state_nxt = state;
        do_move = 1'b0;
        unique case (state)
            FILL: if ((rd_q && cnt == CW'(PACK - 1)) || flush) state_nxt = MOVE;
            MOVE: begin
                do_move = !busy;
                state_nxt = busy ? PEND : FILL;
            end
            PEND: if (m_ready) state_nxt = MOVE;
            default: state_nxt = FILL;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt <= '0;
            rd_q <= 1'b0;
            acc <= '0;
            m_valid <= 1'b0;
            m_data <= '0;
            m_keep <= '0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q <= fifo_rd_en;
            err_underflow <= err_underflow | fifo_underflow;
            if (do_move) begin
                acc <= '0;
                cnt <= '0;
                m_valid <= 1'b1;
                m_data <= acc;
                m_keep <= keep;
            end else begin
                if (m_ready) m_valid <= 1'b0;
                if (rd_q) begin
                    cnt <= cnt + CW'(1);
                    for (int i = 0; i < PACK; i++)
                        if (int'(cnt) == i) acc[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed bench with a FIFO read-port model and output word monitor.
module tb_fifo_word_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [7:0]  fifo_data_out;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] mem [0:255];
    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    int          q_cyc[$];

    fifo_word_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_data_out <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
        if (rst_n && m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_keep.push_back(m_keep);
            q_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) if (fifo_rd_en && fifo_empty) viol <= viol + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic wait_words(input int n, input int budget);
        int t = 0;
        while (q_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("word_count", 64'(q_data.size()), 64'(n));
    endtask

    initial begin
        rst_n = 1'b0;
        m_ready = 1'b0;
        fifo_underflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_keep", 64'(m_keep), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("empty_guard", 64'(fifo_rd_en), 64'd0);
        end
        check("ready_no_valid", 64'(m_valid), 64'd0);

        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(1, 30);
        check("fill_data", 64'(q_data[0]), 64'h44332211);
        check("fill_keep", 64'(q_keep[0]), 64'hF);
        repeat (10) @(negedge clk);
        check("fill_one_pulse", 64'(q_data.size()), 64'd1);

        for (int i = 0; i < 8; i++) push(8'h51 + 8'(i));
        wait_words(3, 40);
        check("rate_w1", 64'(q_data[1]), 64'h54535251);
        check("rate_w2", 64'(q_data[2]), 64'h58575655);
        check("rate_period", 64'(q_cyc[2] - q_cyc[1]), 64'd6);

        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h01 + 8'(i));
        repeat (20) @(negedge clk);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_data", 64'(m_data), 64'h04030201);
        check("bp_keep", 64'(m_keep), 64'hF);
        check("bp_drained", 64'(rd_ptr), 64'(wr_ptr));
        push(8'h09); push(8'h0A); push(8'h0B); push(8'h0C);
        repeat (3) @(negedge clk);
        check("bp_pend_rd_en", 64'(fifo_rd_en), 64'd0);
        check("bp_stable", 64'(m_data), 64'h04030201);
        check("bp_no_xfer", 64'(q_data.size()), 64'd3);
        m_ready = 1'b1;
        wait_words(6, 40);
        check("bp_w1", 64'(q_data[3]), 64'h04030201);
        check("bp_w2", 64'(q_data[4]), 64'h08070605);
        check("bp_w3", 64'(q_data[5]), 64'h0C0B0A09);

        push(8'h11); push(8'h22); push(8'h33);
        repeat (40) @(negedge clk);
`ifdef PACKER_FLUSH_EN
        check("starve_flush_count", 64'(q_data.size()), 64'd7);
        check("starve_flush_data", 64'(q_data[6]), 64'h00332211);
        check("starve_flush_keep", 64'(q_keep[6]), 64'h7);
`else
        check("starve_no_word", 64'(q_data.size()), 64'd6);
        check("starve_no_valid", 64'(m_valid), 64'd0);
        push(8'h44);
        wait_words(7, 30);
        check("starve_data", 64'(q_data[6]), 64'h44332211);
        check("starve_keep", 64'(q_keep[6]), 64'hF);
`endif

        @(negedge clk) fifo_underflow = 1'b1;
        @(negedge clk) fifo_underflow = 1'b0;
        check("uf_set", 64'(err_underflow), 64'd1);
        repeat (5) @(negedge clk);
        check("uf_sticky", 64'(err_underflow), 64'd1);

        push(8'hAA); push(8'hBB);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_data", 64'(m_data), 64'd0);
        check("mid_rst_keep", 64'(m_keep), 64'd0);
        check("mid_rst_err", 64'(err_underflow), 64'd0);
        check("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_words(8, 30);
        check("fresh_data", 64'(q_data[7]), 64'hC4C3C2C1);
        check("fresh_keep", 64'(q_keep[7]), 64'hF);
        check("rd_en_while_empty", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
